// File: rtl/answer_pkg.sv
// answer_pkg: constants and the FSM state type shared by unpack_answer,
// its bus interface and the packing block that produces the padded bytes.
//   SYMBOLS - symbols per answer frame
//   SYM_W   - symbol width in bits
//   BYTE_W  - width of the padded byte carrying one symbol
//   ANS_W   - width of an assembled answer (SYMBOLS * SYM_W)
//   CNT_W   - width of the per-frame symbol counter
package answer_pkg;

    localparam int SYMBOLS = 30;
    localparam int SYM_W   = 5;
    localparam int BYTE_W  = 8;
    localparam int ANS_W   = SYMBOLS * SYM_W;
    localparam int CNT_W   = $clog2(SYMBOLS);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/unpack_answer_if.sv
// unpack_answer_if: byte stream in, assembled answer out.
//   byte_in/byte_valid/byte_ready    - padded symbol byte handshake
//   answer_ack                       - consumer has taken answer_out
//   answer_out/answer_valid          - assembled frame and its valid flag
//   done                             - one-cycle frame completion pulse
//   pad_err                          - completed frame carried nonzero pad bits
// Modports: master = byte producer / answer consumer, slave = unpack_answer.
interface unpack_answer_if
    import answer_pkg::*;
#(
    parameter int SYMBOLS_P = SYMBOLS,
    parameter int SYM_W_P   = SYM_W,
    parameter int BYTE_W_P  = BYTE_W
);
    localparam int ANS_W_P = SYMBOLS_P * SYM_W_P;

    logic [BYTE_W_P-1:0] byte_in;
    logic                byte_valid;
    logic                byte_ready;
    logic                answer_ack;
    logic [ANS_W_P-1:0]  answer_out;
    logic                answer_valid;
    logic                done;
    logic                pad_err;

    modport master (
        output byte_in, byte_valid, answer_ack,
        input  byte_ready, answer_out, answer_valid, done, pad_err
    );

    modport slave (
        input  byte_in, byte_valid, answer_ack,
        output byte_ready, answer_out, answer_valid, done, pad_err
    );

endinterface

// File: rtl/unpack_answer.sv
// unpack_answer: collects SYMBOLS padded bytes, keeps the low SYM_W bits of
// each and packs them into one ANS_W-bit answer, first byte in the MSBs.
// Ports:
//   clk   - system clock, all logic on posedge
//   rst   - synchronous active-high reset (highest priority)
//   clear - synchronous frame abort; in HOLD also acknowledges the answer
//   bus   - unpack_answer_if.slave (byte stream in, answer out)
// Optional feature: define UNPACK_ANSWER_PAD_CHECK_EN to flag frames in which
// any accepted byte had a nonzero pad field; otherwise pad_err is tied 0.
module unpack_answer
    import answer_pkg::*;
#(
    parameter int SYMBOLS = answer_pkg::SYMBOLS,
    parameter int SYM_W   = answer_pkg::SYM_W,
    parameter int BYTE_W  = answer_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    unpack_answer_if.slave    bus
);

    localparam int ANS_W = SYMBOLS * SYM_W;
    localparam int CW    = $clog2(SYMBOLS);
    localparam logic [CW-1:0] LAST = CW'(SYMBOLS - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [ANS_W-1:0]   shift_q, shift_d;
    logic [ANS_W-1:0]   answer_q, answer_d;
    logic               done_q, done_d;

    logic [SYM_W-1:0]   sym;
    logic               take;
    logic               complete;

    assign sym = bus.byte_in[SYM_W-1:0];

    // clear beats an offered byte, so a byte is taken only when clear is low
    assign take     = bus.byte_valid && (state_q == COLLECT) && !clear;
    assign complete = take && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            count_q  <= '0;
            shift_q  <= '0;
            answer_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            answer_q <= answer_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = shift_q;
        answer_d = answer_q;
        done_d   = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (clear) begin
                    count_d = '0;
                    shift_d = '0;
                end else if (complete) begin
                    // last symbol goes straight into the answer; the shift
                    // register restarts empty for the next frame
                    answer_d = {shift_q[ANS_W-SYM_W-1:0], sym};
                    done_d   = 1'b1;
                    count_d  = '0;
                    shift_d  = '0;
                    state_d  = HOLD;
                end else if (take) begin
                    shift_d = {shift_q[ANS_W-SYM_W-1:0], sym};
                    count_d = count_q + 1'b1;
                end
            end
            HOLD: begin
                if (clear || bus.answer_ack) begin
                    state_d = COLLECT;
                end
                if (clear) begin
                    count_d = '0;
                    shift_d = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign bus.byte_ready   = (state_q == COLLECT);
    assign bus.answer_valid = (state_q == HOLD);
    assign bus.answer_out   = answer_q;
    assign bus.done         = done_q;

`ifdef UNPACK_ANSWER_PAD_CHECK_EN
    logic pad_flag_q;
    logic pad_err_q;
    logic pad_now;

    assign pad_now = |bus.byte_in[BYTE_W-1:SYM_W];

    // pad_err reflects the frame just completed and stays until the next
    // completion; the running flag is per-frame
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_flag_q <= 1'b0;
            pad_err_q  <= 1'b0;
        end else if (clear) begin
            pad_flag_q <= 1'b0;
        end else if (complete) begin
            pad_err_q  <= pad_flag_q | pad_now;
            pad_flag_q <= 1'b0;
        end else if (take) begin
            pad_flag_q <= pad_flag_q | pad_now;
        end
    end

    assign bus.pad_err = pad_err_q;
`else
    assign bus.pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_unpack_answer.sv
// tb_unpack_answer: directed self-checking bench for unpack_answer.
// Expected pad_err follows UNPACK_ANSWER_PAD_CHECK_EN when the bench is built.
module tb_unpack_answer;
    import answer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clear;

    int n_cmp = 0;
    int n_err = 0;

    unpack_answer_if bus ();

    unpack_answer #(
        .SYMBOLS (SYMBOLS),
        .SYM_W   (SYM_W),
        .BYTE_W  (BYTE_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef UNPACK_ANSWER_PAD_CHECK_EN
    localparam logic PAD_EXP = 1'b1;
`else
    localparam logic PAD_EXP = 1'b0;
`endif

    task automatic check(input string tag, input logic [ANS_W-1:0] obs,
                         input logic [ANS_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; outputs sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    // Sends SYMBOLS bytes base, base+step, ...; checks no early done and a
    // correct frame right after the last byte's edge.
    task automatic send_frame(input string tag, input logic [7:0] base,
                              input logic [7:0] step,
                              output logic [ANS_W-1:0] exp);
        logic [7:0] b;
        exp = '0;
        for (int i = 0; i < SYMBOLS; i++) begin
            b   = base + 8'(i) * step;
            exp = {exp[ANS_W-SYM_W-1:0], b[SYM_W-1:0]};
            push(b);
            if (i < SYMBOLS - 1) check({tag, "_early_done"}, ANS_W'(bus.done), '0);
        end
        check({tag, "_done"},  ANS_W'(bus.done), ANS_W'(1));
        check({tag, "_valid"}, ANS_W'(bus.answer_valid), ANS_W'(1));
        check({tag, "_ready"}, ANS_W'(bus.byte_ready), '0);
        check({tag, "_answer"}, bus.answer_out, exp);
    endtask

    task automatic ack();
        bus.answer_ack = 1'b1;
        tick();
        bus.answer_ack = 1'b0;
        check("ack_valid", ANS_W'(bus.answer_valid), '0);
        check("ack_ready", ANS_W'(bus.byte_ready), ANS_W'(1));
    endtask

    logic [ANS_W-1:0] exp, prev;
    logic [ANS_W-1:0] all15;

    initial begin
        rst            = 1'b1;
        clear          = 1'b0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        bus.answer_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_answer", bus.answer_out, '0);
        check("rst_valid",  ANS_W'(bus.answer_valid), '0);
        check("rst_done",   ANS_W'(bus.done), '0);
        check("rst_pad",    ANS_W'(bus.pad_err), '0);
        check("rst_ready",  ANS_W'(bus.byte_ready), ANS_W'(1));

        // ramp 0x00..0x1D
        send_frame("ramp", 8'h00, 8'h01, exp);
        check("ramp_msb", ANS_W'(bus.answer_out[ANS_W-1 -: SYM_W]), '0);
        check("ramp_lsb", ANS_W'(bus.answer_out[SYM_W-1:0]), ANS_W'(5'h1D));
        check("ramp_pad", ANS_W'(bus.pad_err), '0);
        tick();
        check("ramp_done_1cyc", ANS_W'(bus.done), '0);
        ack();
        check("ack_retain", bus.answer_out, exp);

        // all 0xFF: all-ones answer, pad bits set
        send_frame("ff", 8'hFF, 8'h00, exp);
        check("ff_ones", bus.answer_out, '1);
        check("ff_pad", ANS_W'(bus.pad_err), ANS_W'(PAD_EXP));
        ack();

        // partial frame aborted by clear, then a frame of 0x15
        for (int i = 0; i < 12; i++) push(8'h03);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_no_done", ANS_W'(bus.done), '0);
        send_frame("s15", 8'h15, 8'h00, exp);
        all15 = {SYMBOLS{5'h15}};
        check("s15_value", bus.answer_out, all15);
        check("s15_pad", ANS_W'(bus.pad_err), '0);

        // HOLD with byte_valid asserted: nothing accepted
        tick();
        bus.byte_in    = 8'h0A;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_ready", ANS_W'(bus.byte_ready), '0);
            check("hold_valid", ANS_W'(bus.answer_valid), ANS_W'(1));
            check("hold_done",  ANS_W'(bus.done), '0);
        end
        bus.byte_valid = 1'b0;
        check("hold_answer", bus.answer_out, all15);
        ack();
        // count unchanged: next frame completes exactly on its 30th byte
        send_frame("after_hold", 8'h07, 8'h07, exp);

        // clear in HOLD acts as ack, answer retained
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("hclr_valid",  ANS_W'(bus.answer_valid), '0);
        check("hclr_ready",  ANS_W'(bus.byte_ready), ANS_W'(1));
        check("hclr_answer", bus.answer_out, exp);

        // reset mid-frame after 20 bytes
        for (int i = 0; i < 20; i++) push(8'(i + 3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_answer", bus.answer_out, '0);
        check("mrst_valid",  ANS_W'(bus.answer_valid), '0);
        check("mrst_done",   ANS_W'(bus.done), '0);
        check("mrst_pad",    ANS_W'(bus.pad_err), '0);
        check("mrst_ready",  ANS_W'(bus.byte_ready), ANS_W'(1));
        send_frame("post_rst", 8'h1D, 8'hFF, exp);
        ack();

        // clear on the same cycle as the 30th byte
        prev = exp;
        for (int i = 0; i < SYMBOLS - 1; i++) push(8'h11);
        clear = 1'b1;
        push(8'h11);
        clear = 1'b0;
        check("c30_done",   ANS_W'(bus.done), '0);
        check("c30_valid",  ANS_W'(bus.answer_valid), '0);
        check("c30_answer", bus.answer_out, prev);
        tick();
        check("c30_done_late", ANS_W'(bus.done), '0);
        // count back at zero: a fresh frame needs all 30 bytes
        send_frame("post_c30", 8'h02, 8'h03, exp);
        ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
